// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the CPU memory-access controller.
package mem_access_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        VERIFY = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; paces how long mem_Read is held.
module mem_wait_counter
    import mem_access_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the CPU memory interface: one load/store outstanding at a time.
// Optional read-back check after every store is enabled by MEMACC_WRITE_VERIFY_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_Write,
    output logic              mem_Read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [CNT_W-1:0] RD_WAIT_C = CNT_W'(RD_WAIT);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_valid_q;
    logic              req_ready_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
`ifdef MEMACC_WRITE_VERIFY_EN
    logic              rsp_err_q;
`endif

    // Reloading throughout IDLE and WRITE guarantees RD_WAIT on entry to READ/VERIFY.
    assign cnt_load = (state_q == IDLE) || (state_q == WRITE);
    assign cnt_dec  = (state_q == READ) || (state_q == VERIFY);

    mem_wait_counter #(
        .W(CNT_W)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(RD_WAIT_C),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef MEMACC_WRITE_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        req_ready_q <= 1'b0;
`ifdef MEMACC_WRITE_VERIFY_EN
                        rsp_err_q   <= 1'b0;
`endif
                        if (req_write) begin
                            state_q     <= WRITE;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= READ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt_zero) begin
                        rsp_rdata_q <= mem_data_out;
                        mem_read_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WRITE: begin
                    mem_write_q <= 1'b0;
                    rsp_rdata_q <= '0;
`ifdef MEMACC_WRITE_VERIFY_EN
                    mem_read_q  <= 1'b1;
                    state_q     <= VERIFY;
`else
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`endif
                end
`ifdef MEMACC_WRITE_VERIFY_EN
                VERIFY: begin
                    if (cnt_zero) begin
                        rsp_rdata_q <= mem_data_out;
                        rsp_err_q   <= (mem_data_out != wdata_q);
                        mem_read_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Address and data are gated so the bus idles at zero between strobes.
    assign mem_address = (mem_read_q || mem_write_q) ? addr_q : '0;
    assign mem_data_in = mem_write_q ? wdata_q : '0;
    assign mem_Read    = mem_read_q;
    assign mem_Write   = mem_write_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rsp_rdata_q;
`ifdef MEMACC_WRITE_VERIFY_EN
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (RD_WAIT 0 and 3) on small memory models.
module tb_mem_access_ctrl;

`ifdef MEMACC_WRITE_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        sel       = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [11:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;

    int checks = 0;
    int errors = 0;
    int overlap_cnt  = 0;
    int addr_bad_cnt = 0;

    logic        req_ready0, rsp_valid0, rsp_write0, rsp_err0, mem_w0, mem_r0;
    logic [11:0] mem_addr0;
    logic [15:0] rsp_rdata0, mem_din0, mem_dout0;
    logic        req_ready1, rsp_valid1, rsp_write1, rsp_err1, mem_w1, mem_r1;
    logic [11:0] mem_addr1;
    logic [15:0] rsp_rdata1, mem_din1, mem_dout1;

    mem_access_ctrl #(.ADDR_W(12), .DATA_W(16), .RD_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(req_ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready && !sel), .rsp_write(rsp_write0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .mem_Write(mem_w0), .mem_Read(mem_r0), .mem_address(mem_addr0),
        .mem_data_in(mem_din0), .mem_data_out(mem_dout0)
    );

    mem_access_ctrl #(.ADDR_W(12), .DATA_W(16), .RD_WAIT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(req_ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready && sel), .rsp_write(rsp_write1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .mem_Write(mem_w1), .mem_Read(mem_r1), .mem_address(mem_addr1),
        .mem_data_in(mem_din1), .mem_data_out(mem_dout1)
    );

    // Memory models: preloaded on reset, write on posedge, combinational read while Read is high.
    logic [15:0] mem0 [0:15];
    logic [15:0] mem1 [0:15];

    always @(posedge clk) begin
        if (rst) begin
            mem0[0] <= 16'h2002; mem0[1] <= 16'h1003; mem0[2] <= 16'h0007; mem0[3] <= 16'h0005;
            mem1[0] <= 16'h2002; mem1[1] <= 16'h1003; mem1[2] <= 16'h0007; mem1[3] <= 16'h0005;
        end else begin
            if (mem_w0) mem0[mem_addr0[3:0]] <= mem_din0;
            if (mem_w1) mem1[mem_addr1[3:0]] <= mem_din1;
        end
    end

    always_comb begin
        mem_dout0 = 16'hDEAD;
        mem_dout1 = 16'hDEAD;
        if (mem_r0) mem_dout0 = mem0[mem_addr0[3:0]];
        if (mem_r1) mem_dout1 = mem1[mem_addr1[3:0]];
`ifdef MEMACC_WRITE_VERIFY_EN
        if (mem_r0 && mem_addr0 == 12'h000) mem_dout0 = 16'h0000;
        if (mem_r1 && mem_addr1 == 12'h000) mem_dout1 = 16'h0000;
`endif
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ((mem_r0 && mem_w0) || (mem_r1 && mem_w1)) overlap_cnt <= overlap_cnt + 1;
            if ((!mem_r0 && !mem_w0 && mem_addr0 != 12'h000) ||
                (!mem_r1 && !mem_w1 && mem_addr1 != 12'h000)) addr_bad_cnt <= addr_bad_cnt + 1;
        end
    end

    logic        obs_req_ready, obs_rsp_valid, obs_rsp_write, obs_rsp_err, obs_mem_r, obs_mem_w;
    logic [15:0] obs_rsp_rdata, obs_mem_din;
    logic [11:0] obs_mem_addr;

    always_comb begin
        obs_req_ready = sel ? req_ready1 : req_ready0;
        obs_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
        obs_rsp_write = sel ? rsp_write1 : rsp_write0;
        obs_rsp_err   = sel ? rsp_err1   : rsp_err0;
        obs_rsp_rdata = sel ? rsp_rdata1 : rsp_rdata0;
        obs_mem_r     = sel ? mem_r1     : mem_r0;
        obs_mem_w     = sel ? mem_w1     : mem_w0;
        obs_mem_din   = sel ? mem_din1   : mem_din0;
        obs_mem_addr  = sel ? mem_addr1  : mem_addr0;
    end

    // One request/response round trip on the selected instance; lat counts posedges from the accept edge.
    task automatic run_txn(input logic wr, input logic [11:0] a, input logic [15:0] d,
                           output int lat, output int rdc, output int wrc,
                           output logic [15:0] din, output logic [15:0] rdata,
                           output logic wecho, output logic err, output logic tmo);
        int n;
        lat = 0; rdc = 0; wrc = 0; din = '0; rdata = '0; wecho = 1'b0; err = 1'b0; tmo = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        n = 0;
        while (!obs_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!obs_req_ready) tmo = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!obs_rsp_valid && lat < 60) begin
            if (obs_mem_r) rdc++;
            if (obs_mem_w) begin
                wrc++;
                din = obs_mem_din;
            end
            @(negedge clk);
            lat++;
        end
        if (!obs_rsp_valid) tmo = 1'b1;
        rdata = obs_rsp_rdata; wecho = obs_rsp_write; err = obs_rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("txn inst=%0d wr=%0d addr=%h wdata=%h lat=%0d rd_cyc=%0d wr_cyc=%0d rdata=%h err=%0d",
                 sel, wr, a, d, lat, rdc, wrc, rdata, err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready0); end
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid0); end
        checks++; if (mem_r0 !== 1'b0 || mem_w0 !== 1'b0) begin errors++; $display("FAIL reset_strobes got r=%b w=%b exp 0/0", mem_r0, mem_w0); end
        checks++; if (mem_addr0 !== 12'h000) begin errors++; $display("FAIL reset_mem_address got %h exp 000", mem_addr0); end
        checks++; if (mem_din0 !== 16'h0000) begin errors++; $display("FAIL reset_mem_data_in got %h exp 0000", mem_din0); end
        checks++; if (rsp_rdata0 !== 16'h0000 || rsp_err0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_fields got rdata=%h err=%b exp 0000/0", rsp_rdata0, rsp_err0); end
        checks++; if (req_ready1 !== 1'b1 || mem_r1 !== 1'b0) begin errors++; $display("FAIL reset_inst1 got ready=%b read=%b exp 1/0", req_ready1, mem_r1); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        int lat, rdc, wrc; logic [15:0] din, rdata; logic we, er, tmo;
        sel = 1'b0;
        run_txn(1'b0, 12'h002, 16'h0000, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL load_timeout got %b exp 0", tmo); end
        checks++; if (rdc != 1) begin errors++; $display("FAIL load_read_cycles got %0d exp 1", rdc); end
        checks++; if (lat != 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
        checks++; if (rdata !== 16'h0007) begin errors++; $display("FAIL load_rdata got %h exp 0007", rdata); end
        checks++; if (we !== 1'b0 || er !== 1'b0) begin errors++; $display("FAIL load_write_err got %b/%b exp 0/0", we, er); end
    endtask

    task automatic test_store_load();
        int lat, rdc, wrc; logic [15:0] din, rdata; logic we, er, tmo;
        sel = 1'b0;
        run_txn(1'b1, 12'h003, 16'hABCD, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL store_timeout got %b exp 0", tmo); end
        checks++; if (wrc != 1) begin errors++; $display("FAIL store_write_cycles got %0d exp 1", wrc); end
        checks++; if (din !== 16'hABCD) begin errors++; $display("FAIL store_data_in got %h exp abcd", din); end
        checks++; if (lat != 2 + VER) begin errors++; $display("FAIL store_latency got %0d exp %0d", lat, 2 + VER); end
        checks++; if (rdc != VER) begin errors++; $display("FAIL store_read_cycles got %0d exp %0d", rdc, VER); end
        checks++; if (we !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL store_write_err got %b/%b exp 1/0", we, er); end
        checks++; if (rdata !== ((VER == 1) ? 16'hABCD : 16'h0000)) begin errors++; $display("FAIL store_rdata got %h", rdata); end
        run_txn(1'b0, 12'h003, 16'h0000, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (rdata !== 16'hABCD) begin errors++; $display("FAIL store_readback got %h exp abcd", rdata); end
        checks++; if (wrc != 0) begin errors++; $display("FAIL load_no_write got %0d exp 0", wrc); end
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", overlap_cnt); end
        checks++; if (addr_bad_cnt != 0) begin errors++; $display("FAIL idle_address got %0d exp 0", addr_bad_cnt); end
    endtask

    task automatic test_rd_wait();
        int lat, rdc, wrc; logic [15:0] din, rdata; logic we, er, tmo;
        sel = 1'b1;
        run_txn(1'b0, 12'h001, 16'h0000, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wait_timeout got %b exp 0", tmo); end
        checks++; if (rdc != 4) begin errors++; $display("FAIL wait_read_cycles got %0d exp 4", rdc); end
        checks++; if (lat != 5) begin errors++; $display("FAIL wait_latency got %0d exp 5", lat); end
        checks++; if (rdata !== 16'h1003) begin errors++; $display("FAIL wait_rdata got %h exp 1003", rdata); end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n; int unstable; int busy_bad;
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h001;
        @(posedge clk);
        @(negedge clk);
        req_addr = 12'h002;
        n = 0;
        while (!rsp_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 16'h1003) begin errors++; $display("FAIL b2b_first got valid=%b rdata=%h exp 1/1003", rsp_valid0, rsp_rdata0); end
        unstable = 0; busy_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 16'h1003 || rsp_write0 !== 1'b0) unstable++;
            if (req_ready0 !== 1'b0 || mem_r0 !== 1'b0) busy_bad++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL b2b_hold_stable got %0d changes exp 0", unstable); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b_hold_busy got %0d bad cycles exp 0", busy_bad); end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1/0", req_ready0, rsp_valid0); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_r0 !== 1'b1 || mem_addr0 !== 12'h002) begin errors++; $display("FAIL b2b_second_accept got read=%b addr=%h exp 1/002", mem_r0, mem_addr0); end
        n = 0;
        while (!rsp_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rsp_rdata0 !== 16'h0007) begin errors++; $display("FAIL b2b_second_rdata got %h exp 0007", rsp_rdata0); end
        $display("txn inst=0 back-to-back loads 001,002 rdata=%h", rsp_rdata0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int seen;
        sel = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_r1 !== 1'b1) begin errors++; $display("FAIL midrst_read_active got %b exp 1", mem_r1); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem_r1 !== 1'b0 || rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin errors++; $display("FAIL midrst_state got read=%b valid=%b ready=%b exp 0/0/1", mem_r1, rsp_valid1, req_ready1); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid1 !== 1'b0 || mem_r1 !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_response got %0d active cycles exp 0", seen); end
        $display("txn inst=1 load 001 aborted by reset");
        sel = 1'b0;
    endtask

`ifdef MEMACC_WRITE_VERIFY_EN
    task automatic test_write_verify();
        int lat, rdc, wrc; logic [15:0] din, rdata; logic we, er, tmo;
        sel = 1'b0;
        run_txn(1'b1, 12'h000, 16'h1234, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (er !== 1'b1 || rdata !== 16'h0000) begin errors++; $display("FAIL verify_mismatch got err=%b rdata=%h exp 1/0000", er, rdata); end
        run_txn(1'b1, 12'h001, 16'h5555, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (er !== 1'b0 || rdata !== 16'h5555) begin errors++; $display("FAIL verify_match got err=%b rdata=%h exp 0/5555", er, rdata); end
        sel = 1'b1;
        run_txn(1'b1, 12'h002, 16'h7777, lat, rdc, wrc, din, rdata, we, er, tmo);
        checks++; if (lat != 6 || rdc != 4) begin errors++; $display("FAIL verify_wait got lat=%0d rd=%0d exp 6/4", lat, rdc); end
        sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_rd_wait();
        test_back_to_back();
        test_reset_mid_read();
`ifdef MEMACC_WRITE_VERIFY_EN
        test_write_verify();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the CPU memory interface.
- Accepts single-word load/store requests from the CPU control unit over a valid/ready handshake.
- Drives the memory strobes: Write, Read, address and data_in. The memory returns data_out combinationally while Read is high, and writes on the posedge while Write is high.
- Returns read data or a store completion through a response handshake. One request is outstanding at a time.

Parameters:
- ADDR_W, 12, width of memory address.
- DATA_W, 16, width of memory word.
- RD_WAIT, 0, extra cycles mem_Read is held before data_out is sampled (0..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  CPU consumes the response.
- rsp_write  out  1  echo of the request type.
- rsp_rdata  out  DATA_W  load data; 0 after a store.
- rsp_err  out  1  write-verify mismatch (see Optional Feature).
- mem_Write  out  1  to the memory Write input.
- mem_Read  out  1  to the memory Read input.
- mem_address  out  ADDR_W  to the memory address input.
- mem_data_in  out  DATA_W  to the memory data_in input.
- mem_data_out  in  DATA_W  from the memory data_out output.

Behaviour:
- FSM states: IDLE, READ, WRITE, VERIFY (feature only), RESP. All outputs are decoded from the state plus latched registers (Moore); there is no combinational path from req_* to mem_*.
- Reset, applied at the next posedge:
  - state = IDLE; latched addr/wdata/write = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - req_ready = 1; rsp_valid = 0; mem_Write = 0; mem_Read = 0; mem_address = 0; mem_data_in = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch addr, wdata and write; load counter = RD_WAIT; go to WRITE if write, else READ.
- READ:
  - mem_Read = 1; mem_address = latched addr.
  - Counter decrements each cycle. In the cycle where counter == 0, capture mem_data_out into rsp_rdata and go to RESP.
  - mem_Read is high for exactly RD_WAIT+1 cycles.
- WRITE:
  - mem_Write = 1 for exactly one cycle; mem_address = addr; mem_data_in = wdata.
  - Next state is RESP, or VERIFY when the feature is enabled.
  - rsp_rdata is cleared to 0.
- RESP:
  - rsp_valid = 1; rsp_write = latched write.
  - Response fields stay stable until the cycle where rsp_ready = 1, then go to IDLE.
  - req_ready = 0 in every non-IDLE state.
- Latency from the accept edge to rsp_valid rising:
  - load: RD_WAIT+2 cycles;
  - store: 2 cycles, or RD_WAIT+3 cycles with verify.
- Invariants and boundary conditions:
  - mem_Read and mem_Write are never high in the same cycle.
  - mem_address is 0 whenever both strobes are low.
  - Address wrap: none. Addresses are forwarded unmodified and out-of-depth addresses are not checked.
  - rsp_ready while rsp_valid = 0 is ignored.
  - req_valid outside IDLE is ignored; the request is not stored and the CPU must hold it.
  - rst mid-operation (any state): return to IDLE on that edge. The pending transaction and response are dropped, and a partially held mem_Read is deasserted. A store that reached WRITE before the reset edge is already committed.
  - Back-to-back requests: the earliest next accept is the cycle after the RESP handshake (IDLE lasts at least 1 cycle).

Optional Feature:
- Macro: MEMACC_WRITE_VERIFY_EN.
- Defined:
  - After WRITE, enter VERIFY: mem_Read = 1 with mem_address = addr for RD_WAIT+1 cycles.
  - On the last verify cycle, compare mem_data_out with the latched wdata; rsp_err = 1 on mismatch, else 0.
  - rsp_rdata = read-back value.
- Undefined: no VERIFY state; rsp_err is tied 0 and the port remains.

Decomposition:
- Package mem_access_pkg:
  - state enum/localparams (IDLE, READ, WRITE, VERIFY, RESP);
  - default ADDR_W/DATA_W constants shared with the memory and the CPU datapath.
- Sub-module: mem_wait_counter, a loadable down-counter with a zero flag. It is reused by READ and VERIFY.

Test Plan:
1. Bench memory preloaded with mem[0..3] = 2002, 1003, 0007, 0005 (hex); RD_WAIT = 0; load addr 2 -> mem_Read high 1 cycle, rsp_valid 2 cycles after accept, rsp_rdata = 0007, rsp_write = 0.
2. Store addr 3 data ABCD, then load addr 3 -> mem_Write high 1 cycle with data_in = ABCD; load returns ABCD; mem_Read never overlaps mem_Write.
3. RD_WAIT = 3; load addr 1 -> mem_Read held 4 cycles, rsp_rdata = 1003, latency 5 cycles.
4. rsp_ready held low 5 cycles with a second req_valid pending -> rsp fields stable and req_ready = 0; the second request is accepted the cycle after the handshake.
5. rst asserted in READ cycle 2 of RD_WAIT = 3 -> next edge: mem_Read = 0, rsp_valid = 0, req_ready = 1, and no response is ever issued.
6. With MEMACC_WRITE_VERIFY_EN and the bench memory forcing mem[0] read-back = 0000: store 0 data 1234 -> rsp_err = 1, rsp_rdata = 0000; store 1 data 5555 -> rsp_err = 0.
